arm_seq_controller: RTL and testbench

Control unit for the 32-bit ARM-subset datapath. It decodes the fetched instruction and drives every datapath control input: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg and PCSrc. It holds the architectural NZCV flags and evaluates condition codes. A small FSM stalls the PC (PCWrite) while a load or store waits on a variable-latency data-memory handshake.

---
 rtl/arm_seq_controller_if.sv | 31 +++
 rtl/arm_seq_controller.sv | 177 +++++++++++++++++
 tb/tb_arm_seq_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/arm_seq_controller_if.sv
// Instruction/flag/memory-handshake bundle between the ARM-subset control unit and its datapath.
// slave = control unit side, master = datapath side.
interface arm_seq_controller_if;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic [1:0]  RegSrc;
   logic        RegWrite;
   logic [1:0]  ImmSrc;
   logic        ALUSrc;
   logic [1:0]  ALUControl;
   logic        MemtoReg;
   logic        PCSrc;
   logic        MemWrite;
   logic        MemReq;
   logic        PCWrite;
   logic [3:0]  Flags;
   logic        Undef;

   modport master (
      output Instr, ALUFlags, MemReady,
      input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
             MemWrite, MemReq, PCWrite, Flags, Undef
   );

   modport slave (
      input  Instr, ALUFlags, MemReady,
      output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
             MemWrite, MemReq, PCWrite, Flags, Undef
   );
endinterface

// File: rtl/arm_seq_controller.sv
// ARM-subset control unit: decode, NZCV flags, condition check, memory-stall FSM.
// Optional feature macro: CTRL_UNDEF_TRAP_EN (undefined encodings trap into HALT).
module arm_seq_controller (
   input logic                 clk,
   input logic                 reset,
   arm_seq_controller_if.slave bus
);

`ifdef CTRL_UNDEF_TRAP_EN
   typedef enum logic [1:0] {RUN, MEM, HALT} state_t;
`else
   typedef enum logic [1:0] {RUN, MEM} state_t;
`endif

   state_t      state_reg, state_next;
   logic [3:0]  flags_reg;
   logic [3:0]  flag_we;
   logic [1:0]  op;
   logic [3:0]  cmd;
   logic        s_bit, rd_pc, condex;
   logic        is_dp, is_mem, is_br, cmd_ok, is_cmp, is_arith;
   logic [1:0]  dp_alu;
   logic        reg_write, mem_write, mem_req, pc_write, pc_src, mem_to_reg;
   logic        unused_bits;

   assign op          = bus.Instr[27:26];
   assign cmd         = bus.Instr[24:21];
   assign s_bit       = bus.Instr[20];
   assign rd_pc       = (bus.Instr[15:12] == 4'hF);
   assign is_dp       = (op == 2'b00);
   assign is_mem      = (op == 2'b01);
   assign is_br       = (op == 2'b10);
   assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0: cond_pass = z;
         4'h1: cond_pass = !z;
         4'h2: cond_pass = cf;
         4'h3: cond_pass = !cf;
         4'h4: cond_pass = n;
         4'h5: cond_pass = !n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = !v;
         4'h8: cond_pass = cf && !z;
         4'h9: cond_pass = !cf || z;
         4'hA: cond_pass = (n == v);
         4'hB: cond_pass = (n != v);
         4'hC: cond_pass = !z && (n == v);
         4'hD: cond_pass = z || (n != v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign condex = cond_pass(bus.Instr[31:28], flags_reg);

   always_comb begin
      cmd_ok   = 1'b1;
      is_cmp   = 1'b0;
      is_arith = 1'b1;
      dp_alu   = 2'b00;
      case (cmd)
         4'b0100: dp_alu = 2'b00;
         4'b0010: dp_alu = 2'b01;
         4'b1010: begin dp_alu = 2'b01; is_cmp = 1'b1; end
         4'b0000: begin dp_alu = 2'b10; is_arith = 1'b0; end
         4'b1100: begin dp_alu = 2'b11; is_arith = 1'b0; end
         default: begin cmd_ok = 1'b0; is_arith = 1'b0; end
      endcase
   end

   // Datapath selects: pure decode of Instr, valid in every state.
   always_comb begin
      bus.RegSrc     = 2'b00;
      bus.ImmSrc     = 2'b00;
      bus.ALUSrc     = 1'b0;
      bus.ALUControl = 2'b00;
      if (is_dp) begin
         bus.ALUSrc     = bus.Instr[25];
         bus.ALUControl = dp_alu;
      end else if (is_mem) begin
         bus.ImmSrc     = 2'b01;
         bus.ALUSrc     = 1'b1;
         bus.ALUControl = bus.Instr[23] ? 2'b00 : 2'b01;
         bus.RegSrc     = bus.Instr[20] ? 2'b00 : 2'b10;
      end else if (is_br) begin
         bus.RegSrc     = 2'b01;
         bus.ImmSrc     = 2'b10;
         bus.ALUSrc     = 1'b1;
      end
   end

   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      mem_to_reg = 1'b0;
      flag_we    = 4'b0000;
      state_next = state_reg;
      case (state_reg)
         RUN: begin
            pc_write = 1'b1;
            if (is_dp && cmd_ok) begin
               if (condex) begin
                  reg_write = !is_cmp;
                  pc_src    = !is_cmp && rd_pc;
                  if (s_bit) flag_we = is_arith ? 4'b1111 : 4'b1100;
               end
            end else if (is_mem) begin
               if (condex) begin
                  mem_req    = 1'b1;
                  pc_write   = 1'b0;
                  state_next = MEM;
               end
            end else if (is_br) begin
               pc_src = condex;
            end
`ifdef CTRL_UNDEF_TRAP_EN
            else begin
               pc_write   = 1'b0;
               state_next = HALT;
            end
`endif
         end
         MEM: begin
            mem_req   = 1'b1;
            mem_write = !bus.Instr[20];
            if (bus.MemReady) begin
               pc_write   = 1'b1;
               reg_write  = bus.Instr[20];
               mem_to_reg = bus.Instr[20];
               pc_src     = bus.Instr[20] && rd_pc;
               state_next = RUN;
            end
         end
         default: ;
      endcase
   end

   // Strobes drop combinationally while reset is held, aborting any access at once.
   assign bus.RegWrite = reg_write & reset;
   assign bus.MemWrite = mem_write & reset;
   assign bus.MemReq   = mem_req   & reset;
   assign bus.PCWrite  = pc_write  & reset;
   assign bus.PCSrc    = pc_src    & reset;
   assign bus.MemtoReg = mem_to_reg;
   assign bus.Flags    = flags_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= RUN;
      else        state_reg <= state_next;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)           flags_reg[gi] <= 1'b0;
         else if (flag_we[gi]) flags_reg[gi] <= bus.ALUFlags[gi];
      end
   end

`ifdef CTRL_UNDEF_TRAP_EN
   logic undef_reg;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  undef_reg <= 1'b0;
      else if (state_reg == RUN && state_next == HALT) undef_reg <= 1'b1;
   end
   assign bus.Undef = undef_reg;
`else
   assign bus.Undef = 1'b0;
`endif

endmodule

// File: tb/tb_arm_seq_controller.sv
// Self-checking bench for arm_seq_controller: directed cases plus randomized instruction stream
// checked against an instruction-level reference model.
module tb_arm_seq_controller;
   logic clk = 1'b0;
   logic reset = 1'b0;
   arm_seq_controller_if bus();

   arm_seq_controller dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] mflags = 4'b0000;
   logic       mundef = 1'b0;
   logic [3:0] cmd_tab [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

   logic [5:0] strb;
   logic [6:0] dec;
   assign strb = {bus.RegWrite, bus.MemWrite, bus.MemReq, bus.PCWrite, bus.PCSrc, bus.MemtoReg};
   assign dec  = {bus.RegSrc, bus.ImmSrc, bus.ALUSrc, bus.ALUControl};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c);
      logic n, z, cf, v;
      {n, z, cf, v} = mflags;
      case (c)
         0: return z;          1: return !z;
         2: return cf;         3: return !cf;
         4: return n;          5: return !n;
         6: return v;          7: return !v;
         8: return cf & !z;    9: return !cf | z;
         10: return n == v;    11: return n != v;
         12: return !z & (n == v);
         13: return z | (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic dp_valid(input logic [3:0] c);
      for (int i = 0; i < 5; i++) if (cmd_tab[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   // Expected {RegSrc,ImmSrc,ALUSrc,ALUControl} from the instruction-class table.
   function automatic logic [6:0] exp_dec(input logic [31:0] ins);
      logic [1:0] alu;
      case (ins[24:21])
         4'b0010, 4'b1010: alu = 2'b01;
         4'b0000:          alu = 2'b10;
         4'b1100:          alu = 2'b11;
         default:          alu = 2'b00;
      endcase
      case (ins[27:26])
         2'b00:   return {2'b00, 2'b00, ins[25], alu};
         2'b01:   return {ins[20] ? 2'b00 : 2'b10, 2'b01, 1'b1, ins[23] ? 2'b00 : 2'b01};
         2'b10:   return {2'b01, 2'b10, 1'b1, 2'b00};
         default: return 7'b0;
      endcase
   endfunction

   task automatic cyc(input logic rdy, input logic [5:0] es, input logic [31:0] ins,
                      input logic chk_dec, input string tag);
      bus.MemReady = rdy;
      @(negedge clk);
      chk({tag, "/strobes"}, 32'(strb), 32'(es));
      if (chk_dec) chk({tag, "/decode"}, 32'(dec), 32'(exp_dec(ins)));
      chk({tag, "/flags"}, 32'(bus.Flags), 32'(mflags));
      chk({tag, "/undef"}, 32'(bus.Undef), 32'(mundef));
      @(posedge clk);
      #1;
   endtask

   // One whole instruction: 1 cycle, or RUN + (waitn stall + 1 ready) MEM cycles.
   task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input int waitn);
      logic pass, ld, r15, undef, valid;
      logic [5:0] s;
      pass  = cond_ok(ins[31:28]);
      ld    = ins[20];
      r15   = (ins[15:12] == 4'hF);
      valid = (ins[27:26] == 2'b00) && dp_valid(ins[24:21]);
      undef = (ins[27:26] == 2'b11) || ((ins[27:26] == 2'b00) && !valid);
      bus.Instr    = ins;
      bus.ALUFlags = af;
      $display("txn instr=%h aluflags=%b flags=%b pass=%0d wait=%0d", ins, af, mflags, pass, waitn);
      if (ins[27:26] == 2'b01 && pass) begin
         cyc(1'($urandom_range(0, 1)), 6'b001000, ins, 1'b1, "mem_run");
         for (int w = 0; w <= waitn; w++) begin
            if (w == waitn) s = {ld, !ld, 1'b1, 1'b1, ld & r15, ld};
            else            s = {1'b0, !ld, 1'b1, 3'b000};
            cyc(w == waitn, s, ins, 1'b1, (w == waitn) ? "mem_rdy" : "mem_stall");
         end
      end else begin
         s = 6'b000100;
         if (valid && pass && ins[24:21] != 4'b1010) s = {1'b1, 2'b00, 1'b1, r15, 1'b0};
         if (ins[27:26] == 2'b10) s = {4'b0001, pass, 1'b0};
         cyc(1'($urandom_range(0, 1)), s, ins, !undef, "single");
         if (valid && pass && ins[20])
            mflags = (ins[24:21] == 4'b0000 || ins[24:21] == 4'b1100) ? {af[3:2], mflags[1:0]} : af;
      end
   endtask

   function automatic logic [31:0] rand_instr(input logic allow_undef);
      logic [31:0] r;
      int k;
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[31:28] = 4'hE;
      if ($urandom_range(0, 5) == 0) r[15:12] = 4'hF;
      k = $urandom_range(0, allow_undef ? 9 : 8);
      if (k < 4) begin
         r[27:26] = 2'b00;
         r[24:21] = cmd_tab[$urandom_range(0, 4)];
      end else if (k < 7) r[27:26] = 2'b01;
      else if (k < 9)     r[27:26] = 2'b10;
      else if ($urandom_range(0, 1) == 0) r[27:26] = 2'b11;
      else begin
         r[27:26] = 2'b00;
         while (dp_valid(r[24:21])) r[24:21] = 4'($urandom);
      end
      return r;
   endfunction

   initial begin
      bus.Instr    = 32'hE0921003;
      bus.ALUFlags = 4'b1111;
      bus.MemReady = 1'b1;
      #12;
      chk("reset/strobes", 32'(strb), 32'h0);
      chk("reset/flags", 32'(bus.Flags), 32'h0);
      chk("reset/undef", 32'(bus.Undef), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      run_instr(32'h0A000002, 4'b0000, 0);   // BEQ, Z clear
      run_instr(32'hE0921003, 4'b0100, 0);   // ADDS R1,R2,R3
      run_instr(32'hE0021003, 4'b1010, 0);   // AND no S
      run_instr(32'hE1510002, 4'b0100, 0);   // CMP sets Z
      run_instr(32'h0A000002, 4'b0000, 0);   // BEQ taken
      run_instr(32'hE5910004, 4'b0000, 3);   // LDR, 3 stall cycles
      run_instr(32'hE5810004, 4'b0000, 0);   // STR, ready first MEM cycle
      run_instr(32'hE591F004, 4'b0000, 1);   // LDR into PC
      run_instr(32'h05810004, 4'b0000, 0);   // STREQ, Z still set -> passes
      run_instr(32'hF0921003, 4'b1111, 0);   // never

      // Abort an in-flight STR with reset.
      bus.Instr = 32'hE5810004;
      bus.MemReady = 1'b0;
      @(posedge clk); #1;
      #2;
      reset = 1'b0;
      #1;
      mflags = 4'b0000;
      chk("abort/strobes", 32'(strb), 32'h0);
      chk("abort/flags", 32'(bus.Flags), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      run_instr(32'hE0821003, 4'b0000, 0);   // ADD: RUN after release
      run_instr(32'hE5910004, 4'b0000, 2);

      for (int i = 0; i < 200; i++)
`ifdef CTRL_UNDEF_TRAP_EN
         run_instr(rand_instr(1'b0), 4'($urandom), $urandom_range(0, 3));
      bus.Instr = 32'hEC000000;
      cyc(1'b0, 6'b000000, 32'hEC000000, 1'b0, "trap");
      mundef = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.Instr = (i == 0) ? 32'hEC000000 : 32'hE0821003;
         cyc(1'b1, 6'b000000, bus.Instr, 1'b0, "halt");
      end
`else
         run_instr(rand_instr(1'b1), 4'($urandom), $urandom_range(0, 3));
      run_instr(32'hEC000000, 4'b1111, 0);
      run_instr(32'hE0D00000, 4'b1111, 0);   // unlisted DP cmd 0110
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
